serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder that sits directly upstream of the 1-bit adder cells. It holds two WIDTH-bit operands and feeds them LSB-first, one bit per clock, into a full-adder cell built from two `add1` half adders. The carry is kept in a flip-flop between cycles, and each sum bit is shifted into a result register. It is our first multi-bit arithmetic block and trades WIDTH cycles of latency for a single adder cell.

## Interface
- `WIDTH`, 8, operand and result width in bits; legal range ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `a_in`  in  WIDTH  operand A; captured on an accepted `start`.
- `b_in`  in  WIDTH  operand B; captured on an accepted `start`.
- `busy`  out  1  high in SHIFT and DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `sum_out`  out  WIDTH  result, A+B mod 2^WIDTH.
- `carry_out`  out  1  carry out of the MSB.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If `start`=1 at a rising edge: load A and B shift registers from `a_in`/`b_in`, clear the carry flip-flop, clear the bit counter, go to SHIFT.
  - Otherwise hold all state.
- SHIFT, each cycle:
  - Full-adder cell inputs: `a=A[0]`, `b=B[0]`, `cin=carry_q`.
  - `s = a^b^cin`.
  - `cout = (a&b) | (cin&(a^b))`.
  - `carry_q <= cout`.
  - The result register shifts right with `s` entering at bit WIDTH-1.
  - A and B shift right with zero fill.
  - The counter increments.
  - When the counter reaches WIDTH-1 (the last bit is being processed), go to DONE on the next edge.
- DONE:
  - `done`=1 for exactly one cycle.
  - `sum_out` equals the result register; `carry_out` equals `carry_q`.
  - Go to IDLE unconditionally.
- `sum_out` and `carry_out` are driven from registers. Both hold their last value until the next accepted `start`, when they are cleared to 0.
- `start` in SHIFT or DONE is ignored; no queuing.
- `a_in`/`b_in` may change freely after acceptance without affecting the result.
- Counter width: `$clog2(WIDTH)`. No arithmetic wider than 1 bit exists outside the counter.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `busy`=0, `done`=0, `sum_out`=0, `carry_out`=0, carry and counter cleared.
- Reset has priority over `start` and takes effect from any state, including mid-SHIFT. The partial result is discarded.
- Latency: `start` accepted at edge k → `busy`=1 after edge k → `done`=1 during the cycle after edge k+WIDTH+1.
  - For WIDTH=8, `done` rises 9 edges after acceptance.
- Throughput: one addition per WIDTH+2 cycles.
- A `start` held high through DONE is accepted at the first edge back in IDLE, giving back-to-back operations with one idle cycle.
- `done` and `busy` are registered outputs with no combinational path from inputs.

## Structure
- Package `serial_adder_pkg`:
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;`
  - `localparam int SA_DEFAULT_WIDTH = 8;`
- Sub-module `full_add1`:
  - Two `add1` instances plus an OR gate on the two carries.
  - Purely combinational; instantiated once in `serial_adder`.
- `serial_adder` contains the FSM, operand shift registers, result shift register, counter and carry flip-flop.

## Test plan
- WIDTH=8, `a_in`=0x03, `b_in`=0x05, pulse `start` → `done` 9 edges later, `sum_out`=0x08, `carry_out`=0, `busy` high for 9 cycles.
- `a_in`=0xFF, `b_in`=0x01 → `sum_out`=0x00, `carry_out`=1; then 0xFF+0xFF → `sum_out`=0xFE, `carry_out`=1.
- Start 0x10+0x20, then pulse `start` with 0xAA+0x55 three cycles later → second request ignored; result 0x30, carry 0, exactly one `done` pulse.
- Start 0x7F+0x01, drop `rst_n` for one edge at SHIFT cycle 4 → all outputs 0, state IDLE, no `done`; a new start of 0x7F+0x01 then gives 0x80, carry 0.
- Hold `start`=1 continuously with 0x01+0x01 → `done` pulses every 10 cycles, each with `sum_out`=0x02.
- Random operand pairs (≥ 1000) at WIDTH=8 and WIDTH=3, checked against `{carry_out,sum_out} == a_in+b_in`.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and defaults
// for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/add1.sv
// add1: 1-bit half adder cell.
module add1 (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;

endmodule

// File: rtl/full_add1.sv
// full_add1: 1-bit full adder built from two
// add1 half adders and an OR on their carries.
module full_add1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    add1 u_ha0 (
        .i_a (i_a),
        .i_b (i_b),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    add1 u_ha1 (
        .i_a (w_s0),
        .i_b (i_cin),
        .o_s (o_s),
        .o_c (w_c1)
    );

    assign o_cout = w_c0 | w_c1;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder,
// one full_add1 cell, WIDTH+2 cycles per add.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        r_state;
    sa_state_t        w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_done;
    logic             w_s;
    logic             w_c;

    full_add1 u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (r_cnt == LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are loaded while leaving DONE,
    // so done lands in the following IDLE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_res   <= '0;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                        r_cout  <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                end
                DONE: begin
                    r_done <= 1'b1;
                    r_sum  <= r_res;
                    r_cout <= r_carry;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign sum_out   = r_sum;
    assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven and scoreboard
// checks of serial_adder at WIDTH=8 and WIDTH=3.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, st8, busy8, done8, co8;
    logic [7:0] a8, b8, sum8;
    logic       rst3, st3, busy3, done3, co3;
    logic [2:0] a3, b3, sum3;

    int checks   = 0;
    int failures = 0;

    logic [8:0] q8[$];
    logic [3:0] q3[$];
    logic [8:0] e8;
    logic [3:0] e3;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] e;
        int         ign;
    } vec_t;

    vec_t tbl[6];

    serial_adder #(.WIDTH(8)) u8 (
        .clk       (clk),
        .rst_n     (rst8),
        .start     (st8),
        .a_in      (a8),
        .b_in      (b8),
        .busy      (busy8),
        .done      (done8),
        .sum_out   (sum8),
        .carry_out (co8)
    );

    serial_adder #(.WIDTH(3)) u3 (
        .clk       (clk),
        .rst_n     (rst3),
        .start     (st3),
        .a_in      (a3),
        .b_in      (b3),
        .busy      (busy3),
        .done      (done3),
        .sum_out   (sum3),
        .carry_out (co3)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timed out", nm);
    endtask

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done8_unexp: got %0h with empty scoreboard",
                         {co8, sum8});
            end else begin
                e8 = q8.pop_front();
                chk("sum8", {23'd0, co8, sum8}, {23'd0, e8});
            end
        end
    end

    always @(negedge clk) begin
        if (done3 === 1'b1) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done3_unexp: got %0h with empty scoreboard",
                         {co3, sum3});
            end else begin
                e3 = q3.pop_front();
                chk("sum3", {28'd0, co3, sum3}, {28'd0, e3});
            end
        end
    end

    task automatic op8(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [8:0] e,
                       input int ign,
                       input int rst_at,
                       input string nm);
        int nd, nb, dm;
        @(negedge clk);
        a8  = a;
        b8  = b;
        st8 = 1'b1;
        q8.push_back(e);
        nd = 0;
        nb = 0;
        dm = -1;
        for (int m = 0; m < 16; m++) begin
            @(negedge clk);
            if (m == 0) begin
                st8 = 1'b0;
                a8  = ~a;
                b8  = 8'($urandom);
                chk({nm, "_clr"}, {23'd0, co8, sum8}, 32'd0);
            end
            if (m == ign) begin
                st8 = 1'b1;
                a8  = 8'hAA;
                b8  = 8'h55;
            end
            if (m == ign + 1) st8 = 1'b0;
            if (m == rst_at) rst8 = 1'b0;
            if (m == rst_at + 1) begin
                rst8 = 1'b1;
                q8.delete();
                chk({nm, "_rstout"},
                    {21'd0, busy8, done8, co8, sum8}, 32'd0);
            end
            if (busy8) nb++;
            if (done8) begin
                nd++;
                dm = m;
            end
        end
        if (rst_at > 16) begin
            chk({nm, "_lat"}, dm, 9);
            chk({nm, "_busy"}, nb, 9);
            chk({nm, "_ndone"}, nd, 1);
            chk({nm, "_hold"}, {23'd0, co8, sum8}, {23'd0, e});
        end else begin
            chk({nm, "_ndone"}, nd, 0);
            chk({nm, "_idle"}, {31'd0, busy8}, 32'd0);
        end
    endtask

    task automatic b2b8();
        int nd, last, bad, first;
        @(negedge clk);
        a8  = 8'h01;
        b8  = 8'h01;
        st8 = 1'b1;
        repeat (5) q8.push_back(9'h002);
        nd    = 0;
        last  = -1;
        bad   = 0;
        first = -1;
        for (int m = 0; m < 60; m++) begin
            @(negedge clk);
            if (m == 41) st8 = 1'b0;
            if (done8) begin
                if (last >= 0 && m - last != 10) bad++;
                if (first < 0) first = m;
                last = m;
                nd++;
            end
        end
        chk("b2b_count", nd, 5);
        chk("b2b_first", first, 9);
        chk("b2b_gaps", bad, 0);
    endtask

    task automatic rnd8(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            t = 0;
            while (busy8 && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (t >= 40) timeout("rnd8_idle");
            a8  = a;
            b8  = b;
            st8 = 1'b1;
            q8.push_back({1'b0, a} + {1'b0, b});
            @(negedge clk);
            st8 = 1'b0;
        end
        t = 0;
        while (q8.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("q8_empty", q8.size(), 0);
    endtask

    task automatic rnd3(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            logic [2:0] a, b;
            a = 3'($urandom);
            b = 3'($urandom);
            if (i == 0) begin
                a = 3'd7;
                b = 3'd1;
            end
            if (i == 1) begin
                a = 3'd7;
                b = 3'd7;
            end
            t = 0;
            while (busy3 && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (t >= 40) timeout("rnd3_idle");
            a3  = a;
            b3  = b;
            st3 = 1'b1;
            q3.push_back({1'b0, a} + {1'b0, b});
            @(negedge clk);
            st3 = 1'b0;
        end
        t = 0;
        while (q3.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("q3_empty", q3.size(), 0);
    endtask

    initial begin
        tbl[0] = '{8'h03, 8'h05, 9'h008, 99};
        tbl[1] = '{8'hFF, 8'h01, 9'h100, 99};
        tbl[2] = '{8'hFF, 8'hFF, 9'h1FE, 99};
        tbl[3] = '{8'h10, 8'h20, 9'h030, 3};
        tbl[4] = '{8'h80, 8'h80, 9'h100, 99};
        tbl[5] = '{8'h00, 8'h00, 9'h000, 99};

        rst8 = 1'b0;
        rst3 = 1'b0;
        st8  = 1'b0;
        st3  = 1'b0;
        a8   = 8'h5A;
        b8   = 8'hA5;
        a3   = 3'd0;
        b3   = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst8", {21'd0, busy8, done8, co8, sum8}, 32'd0);
        chk("rst3", {26'd0, busy3, done3, co3, sum3}, 32'd0);
        rst8 = 1'b1;
        rst3 = 1'b1;

        for (int i = 0; i < 6; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].e,
                tbl[i].ign, 99, $sformatf("vec%0d", i));
        end

        op8(8'h7F, 8'h01, 9'h080, 99, 4, "rst_mid");
        op8(8'h7F, 8'h01, 9'h080, 99, 99, "post_rst");

        b2b8();

        fork
            rnd8(1000);
            rnd3(1000);
        join

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
